// File: rtl/result_bus_streamer.sv
// Result bus streamer: captures a wide multiplier result on a done pulse and
// streams it out least-significant word first over a valid/ready word bus.
// A result arriving while a stream is still in progress is dropped and flagged
// in a sticky overrun bit. The one exception is a result that arrives together
// with the last-word transfer: it chains straight into the next stream.
module result_bus_streamer #(
    parameter int unsigned input_size = 1024,
    parameter int unsigned word_size  = 64,
    // input_size must be an integer multiple of word_size
    localparam int unsigned NUM_WORDS = input_size / word_size,
    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  done,
    input  logic [input_size-1:0] result,
    output logic [word_size-1:0]  bus,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic                  bus_last,
    output logic [IDX_W-1:0]      word_idx,
    output logic                  busy,
    output logic                  overrun,
    output logic [7:0]            result_count
);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    localparam logic [IDX_W-1:0] LastIdx     = IDX_W'(NUM_WORDS - 1);
    localparam logic             FirstIsLast = (NUM_WORDS == 1);

    state_e                state_q;
    logic [input_size-1:0] hold_q;
    logic [input_size-1:0] hold_nxt;
    logic [word_size-1:0]  bus_q;
    logic                  valid_q;
    logic                  last_q;
    logic                  busy_q;
    logic                  ovr_q;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_inc;
    logic [7:0]            count_q;
    logic                  at_last;

    // Next-word helpers: hold_q always has the word on the bus in its low slice
    always_comb begin
        hold_nxt = hold_q >> word_size;
        idx_inc  = idx_q + IDX_W'(1);
        at_last  = (idx_q == LastIdx);
    end

    // Streaming FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            hold_q  <= '0;
            bus_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            idx_q   <= '0;
            count_q <= 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (done) begin
                        state_q <= StStream;
                        hold_q  <= result;
                        bus_q   <= result[word_size-1:0];
                        valid_q <= 1'b1;
                        last_q  <= FirstIsLast;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                    end
                end
                StStream: begin
                    if (bus_ready && at_last) begin
                        count_q <= count_q + 8'd1;
                        if (done) begin
                            // Chain the new result with no idle gap
                            hold_q <= result;
                            bus_q  <= result[word_size-1:0];
                            last_q <= FirstIsLast;
                            idx_q  <= '0;
                        end else begin
                            state_q <= StIdle;
                            bus_q   <= '0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            idx_q   <= '0;
                        end
                    end else begin
                        // A result mid-stream is dropped; the stream continues untouched
                        if (done) begin
                            ovr_q <= 1'b1;
                        end
                        if (bus_ready) begin
                            hold_q <= hold_nxt;
                            bus_q  <= hold_nxt[word_size-1:0];
                            idx_q  <= idx_inc;
                            last_q <= (idx_inc == LastIdx);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus          = bus_q;
    assign bus_valid    = valid_q;
    assign bus_last     = last_q;
    assign word_idx     = idx_q;
    assign busy         = busy_q;
    assign overrun      = ovr_q;
    assign result_count = count_q;

endmodule

// File: tb/tb_result_bus_streamer.sv
// Bench for result_bus_streamer at default parameters (1024-bit result, 64-bit words).
// The expected word stream is derived directly from the captured result value.
module tb_result_bus_streamer;

    logic          clk = 1'b0;
    logic          reset;
    logic          done;
    logic [1023:0] result;
    logic [63:0]   bus;
    logic          bus_valid;
    logic          bus_ready;
    logic          bus_last;
    logic [3:0]    word_idx;
    logic          busy;
    logic          overrun;
    logic [7:0]    result_count;

    int total = 0;
    int bad   = 0;
    int exp_count = 0;

    result_bus_streamer #(
        .input_size(1024),
        .word_size (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .done        (done),
        .result      (result),
        .bus         (bus),
        .bus_valid   (bus_valid),
        .bus_ready   (bus_ready),
        .bus_last    (bus_last),
        .word_idx    (word_idx),
        .busy        (busy),
        .overrun     (overrun),
        .result_count(result_count)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] word_of(input logic [1023:0] d, input int n);
        return d[n*64 +: 64];
    endfunction

    function automatic logic [1023:0] basic_result();
        logic [1023:0] r;
        for (int n = 0; n < 16; n++) r[n*64 +: 64] = 64'h1000_0000_0000_0000 + 64'(n);
        return r;
    endfunction

    function automatic logic [1023:0] rand_result();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b1; done = 1'b1; bus_ready = 1'b1; result = rand_result();
        repeat (2) @(negedge clk);
        total++; if (bus !== 64'd0) begin bad++; $display("FAIL reset_bus got=%h exp=0", bus); end
        total++; if (bus_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus_valid); end
        total++; if (bus_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", bus_last); end
        total++; if (word_idx !== 4'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", word_idx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        total++; if (result_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", result_count); end
        done = 1'b0; reset = 1'b0; exp_count = 0;
    endtask

    task automatic test_basic();
        logic [1023:0] r;
        r = basic_result();
        @(negedge clk); result = r; done = 1'b1; bus_ready = 1'b1;
        @(negedge clk); done = 1'b0; result = '0;
        for (int n = 0; n < 16; n++) begin
            total++; if (bus !== word_of(r, n)) begin bad++; $display("FAIL basic_bus n=%0d got=%h exp=%h", n, bus, word_of(r, n)); end
            total++; if (bus_valid !== 1'b1) begin bad++; $display("FAIL basic_valid n=%0d got=%b exp=1", n, bus_valid); end
            total++; if (bus_last !== (n == 15)) begin bad++; $display("FAIL basic_last n=%0d got=%b exp=%b", n, bus_last, n == 15); end
            total++; if (word_idx !== 4'(n)) begin bad++; $display("FAIL basic_idx n=%0d got=%0d exp=%0d", n, word_idx, n); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy n=%0d got=%b exp=1", n, busy); end
            @(negedge clk);
        end
        exp_count++;
        total++; if (bus_valid !== 1'b0) begin bad++; $display("FAIL basic_end_valid got=%b exp=0", bus_valid); end
        total++; if (bus !== 64'd0) begin bad++; $display("FAIL basic_end_bus got=%h exp=0", bus); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_end_busy got=%b exp=0", busy); end
        total++; if (result_count !== 8'(exp_count)) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", result_count, exp_count); end
    endtask

    // rnd=0: fixed ready pattern 1,0,0,1,0,0...; rnd=1: random data and random ready
    task automatic test_backpressure(input bit rnd);
        logic [1023:0] r;
        int n, cyc;
        bit xfer;
        r = rnd ? rand_result() : basic_result();
        @(negedge clk); result = r; done = 1'b1; bus_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk); done = 1'b0;
        n = 0; cyc = 0;
        while (n < 16 && cyc < 400) begin
            total++; if (bus !== word_of(r, n)) begin bad++; $display("FAIL bp_bus n=%0d cyc=%0d got=%h exp=%h", n, cyc, bus, word_of(r, n)); end
            total++; if (bus_valid !== 1'b1) begin bad++; $display("FAIL bp_valid n=%0d got=%b exp=1", n, bus_valid); end
            total++; if (word_idx !== 4'(n)) begin bad++; $display("FAIL bp_idx n=%0d got=%0d exp=%0d", n, word_idx, n); end
            total++; if (bus_last !== (n == 15)) begin bad++; $display("FAIL bp_last n=%0d got=%b exp=%b", n, bus_last, n == 15); end
            xfer = bus_ready;
            @(negedge clk);
            if (xfer) n++;
            cyc++;
            bus_ready = rnd ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
        end
        total++; if (n != 16) begin bad++; $display("FAIL bp_transfers got=%0d exp=16", n); end
        exp_count++;
        // Idle exactly once the 16th transfer has happened, so cycles = 16 + stalls
        total++; if (bus_valid !== 1'b0) begin bad++; $display("FAIL bp_end_valid got=%b exp=0", bus_valid); end
        total++; if (result_count !== 8'(exp_count)) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", result_count, exp_count); end
        bus_ready = 1'b1;
    endtask

    task automatic test_chained();
        logic [1023:0] r1, r2;
        r1 = basic_result();
        for (int n = 0; n < 16; n++) r2[n*64 +: 64] = 64'(n);
        @(negedge clk); result = r1; done = 1'b1; bus_ready = 1'b1;
        @(negedge clk); done = 1'b0;
        for (int n = 0; n < 16; n++) begin
            total++; if (bus !== word_of(r1, n)) begin bad++; $display("FAIL chain1_bus n=%0d got=%h exp=%h", n, bus, word_of(r1, n)); end
            if (n == 15) begin result = r2; done = 1'b1; end
            @(negedge clk);
            done = 1'b0;
        end
        for (int n = 0; n < 16; n++) begin
            total++; if (bus !== word_of(r2, n)) begin bad++; $display("FAIL chain2_bus n=%0d got=%h exp=%h", n, bus, word_of(r2, n)); end
            total++; if (bus_valid !== 1'b1) begin bad++; $display("FAIL chain2_valid n=%0d got=%b exp=1", n, bus_valid); end
            total++; if (word_idx !== 4'(n)) begin bad++; $display("FAIL chain2_idx n=%0d got=%0d exp=%0d", n, word_idx, n); end
            total++; if (overrun !== 1'b0) begin bad++; $display("FAIL chain2_overrun n=%0d got=%b exp=0", n, overrun); end
            @(negedge clk);
        end
        exp_count += 2;
        total++; if (bus_valid !== 1'b0) begin bad++; $display("FAIL chain_end_valid got=%b exp=0", bus_valid); end
        total++; if (result_count !== 8'(exp_count)) begin bad++; $display("FAIL chain_count got=%0d exp=%0d", result_count, exp_count); end
    endtask

    task automatic test_overrun();
        logic [1023:0] r;
        r = basic_result();
        @(negedge clk); result = r; done = 1'b1; bus_ready = 1'b1;
        @(negedge clk); done = 1'b0;
        for (int n = 0; n < 16; n++) begin
            total++; if (bus !== word_of(r, n)) begin bad++; $display("FAIL ovr_bus n=%0d got=%h exp=%h", n, bus, word_of(r, n)); end
            total++; if (overrun !== (n > 5)) begin bad++; $display("FAIL ovr_flag n=%0d got=%b exp=%b", n, overrun, n > 5); end
            if (n == 5) begin result = '1; done = 1'b1; end
            @(negedge clk);
            done = 1'b0;
        end
        exp_count++;
        total++; if (bus_valid !== 1'b0) begin bad++; $display("FAIL ovr_end_valid got=%b exp=0", bus_valid); end
        total++; if (result_count !== 8'(exp_count)) begin bad++; $display("FAIL ovr_count got=%0d exp=%0d", result_count, exp_count); end
        repeat (3) @(negedge clk);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    endtask

    task automatic test_reset_mid();
        logic [1023:0] r, r2;
        r = rand_result(); r2 = rand_result();
        @(negedge clk); result = r; done = 1'b1; bus_ready = 1'b1;
        @(negedge clk); done = 1'b0;
        for (int n = 0; n < 8; n++) begin
            total++; if (bus !== word_of(r, n)) begin bad++; $display("FAIL rmid_bus n=%0d got=%h exp=%h", n, bus, word_of(r, n)); end
            if (n == 7) reset = 1'b1;
            @(negedge clk);
        end
        exp_count = 0;
        total++; if (bus_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", bus_valid); end
        total++; if (bus !== 64'd0) begin bad++; $display("FAIL rmid_bus_zero got=%h exp=0", bus); end
        total++; if (word_idx !== 4'd0) begin bad++; $display("FAIL rmid_idx got=%0d exp=0", word_idx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rmid_overrun got=%b exp=0", overrun); end
        total++; if (result_count !== 8'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", result_count); end
        // done in the very first cycle after reset deasserts
        reset = 1'b0; result = r2; done = 1'b1;
        @(negedge clk); done = 1'b0;
        for (int n = 0; n < 16; n++) begin
            total++; if (bus !== word_of(r2, n)) begin bad++; $display("FAIL rmid2_bus n=%0d got=%h exp=%h", n, bus, word_of(r2, n)); end
            total++; if (bus_valid !== 1'b1) begin bad++; $display("FAIL rmid2_valid n=%0d got=%b exp=1", n, bus_valid); end
            @(negedge clk);
        end
        exp_count++;
        total++; if (result_count !== 8'(exp_count)) begin bad++; $display("FAIL rmid2_count got=%0d exp=%0d", result_count, exp_count); end
    endtask

    task automatic test_wrap();
        reset = 1'b1; @(negedge clk); reset = 1'b0; exp_count = 0;
        bus_ready = 1'b1;
        for (int s = 0; s < 256; s++) begin
            @(negedge clk); result = rand_result(); done = 1'b1;
            @(negedge clk); done = 1'b0;
            repeat (16) @(negedge clk);
            exp_count++;
            if (s == 254) begin
                total++; if (result_count !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d exp=255", result_count); end
            end
        end
        total++; if (result_count !== 8'(exp_count % 256)) begin bad++; $display("FAIL wrap_zero got=%0d exp=%0d", result_count, exp_count % 256); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap_busy got=%b exp=0", busy); end
    endtask

    initial begin
        reset = 1'b1; done = 1'b0; bus_ready = 1'b0; result = '0;
        test_reset();
        test_basic();
        test_backpressure(1'b0);
        for (int i = 0; i < 4; i++) test_backpressure(1'b1);
        test_chained();
        test_overrun();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
